// File: rtl/belt_warn_pkg.sv
// Shared types and default constants for the seat-belt warning controller.
package belt_warn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WARN_CHIME = 2'd1,
        WARN_QUIET = 2'd2
    } belt_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_BLINK_HALF      = 8;
    localparam int DEF_CHIME_CYCLES    = 32;

    // Bits needed for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/belt_debounce.sv
// Single-bit switch debouncer: a changed input is accepted only after it
// holds for DEBOUNCE_CYCLES consecutive samples.
module belt_debounce
    import belt_warn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_x,
    output logic o_dx
);

    localparam int            CW       = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_dx;

    // Any sample matching the accepted value restarts the qualification run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dx  <= 1'b0;
            r_cnt <= '0;
        end else if (i_x == r_dx) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_dx  <= i_x;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_dx = r_dx;

endmodule

// File: rtl/belt_warn_ctrl.sv
// Seat-belt warning controller: debounced key/seat/belt switches drive a
// registered warning flag, a blinking lamp and a time-limited chime.
module belt_warn_ctrl
    import belt_warn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int BLINK_HALF      = DEF_BLINK_HALF,
    parameter int CHIME_CYCLES    = DEF_CHIME_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic k,
    input  logic p,
    input  logic s,
    output logic w,
    output logic lamp,
    output logic chime
);

    localparam int             BW         = cntWidth(2 * BLINK_HALF);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0]  BLINK_ON   = BW'(BLINK_HALF);
    localparam int             CCW        = cntWidth(CHIME_CYCLES);
    localparam logic [CCW-1:0] CHIME_LAST = CCW'(CHIME_CYCLES - 1);

    logic w_dk;
    logic w_dp;
    logic w_ds;
    logic w_cond;

    belt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debK (
        .clk (clk), .rst (rst), .i_x (k), .o_dx (w_dk)
    );
    belt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debP (
        .clk (clk), .rst (rst), .i_x (p), .o_dx (w_dp)
    );
    belt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debS (
        .clk (clk), .rst (rst), .i_x (s), .o_dx (w_ds)
    );

    assign w_cond = w_dk & w_dp & ~w_ds;

    belt_state_e    r_state;
    logic [CCW-1:0] r_chimeCnt;
    logic [BW-1:0]  r_blinkCnt;
    logic           r_w;
    logic           r_lamp;
    logic           r_chime;
    logic [BW-1:0]  w_blinkNext;

    // Entering a warning episode starts the blink phase at zero so the lamp leads with "on".
    always_comb begin
        w_blinkNext = '0;
        if (r_state != IDLE && r_blinkCnt != BLINK_LAST) begin
            w_blinkNext = r_blinkCnt + 1'b1;
        end
    end

    // Outputs are registered alongside the state so they change on the same edge as w.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_chimeCnt <= '0;
            r_blinkCnt <= '0;
            r_w        <= 1'b0;
            r_lamp     <= 1'b0;
            r_chime    <= 1'b0;
        end else begin
            r_w <= w_cond;
            if (!w_cond) begin
                r_state    <= IDLE;
                r_chimeCnt <= '0;
                r_blinkCnt <= '0;
                r_lamp     <= 1'b0;
                r_chime    <= 1'b0;
            end else begin
                r_blinkCnt <= w_blinkNext;
                r_lamp     <= (w_blinkNext < BLINK_ON);
                case (r_state)
                    IDLE: begin
                        r_state    <= WARN_CHIME;
                        r_chimeCnt <= '0;
                        r_chime    <= 1'b1;
                    end
                    WARN_CHIME: begin
                        if (r_chimeCnt == CHIME_LAST) begin
                            r_state <= WARN_QUIET;
                            r_chime <= 1'b0;
                        end else begin
                            r_chimeCnt <= r_chimeCnt + 1'b1;
                            r_chime    <= 1'b1;
                        end
                    end
                    WARN_QUIET: begin
                        r_chime <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_chime <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w     = r_w;
    assign lamp  = r_lamp;
    assign chime = r_chime;

endmodule

// File: tb/tb_belt_warn_ctrl.sv
// Self-checking bench for belt_warn_ctrl: directed scenarios plus random
// switch activity compared against an episode-age reference model.
module tb_belt_warn_ctrl;

    localparam int D  = 4;
    localparam int BH = 8;
    localparam int CC = 32;

    logic clk = 1'b0;
    logic rst;
    logic k;
    logic p;
    logic s;
    logic w;
    logic lamp;
    logic chime;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: sample history window, accepted values, episode age.
    logic [2:0] histQ[$];
    logic [2:0] dm = 3'b000;
    logic       wM = 1'b0;
    int         ageM = 0;

    belt_warn_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .BLINK_HALF      (BH),
        .CHIME_CYCLES    (CC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .k     (k),
        .p     (p),
        .s     (s),
        .w     (w),
        .lamp  (lamp),
        .chime (chime)
    );

    always #5 clk = ~clk;

    // An input is accepted once the last D samples all disagree with its accepted value.
    task automatic modelEdge(input logic [2:0] smp, input logic rr);
        logic condOld;
        logic allDiff;
        condOld = dm[2] & dm[1] & ~dm[0];
        if (rr) begin
            dm   = 3'b000;
            wM   = 1'b0;
            ageM = 0;
            histQ.delete();
        end else begin
            if (condOld) ageM = wM ? ageM + 1 : 0;
            else         ageM = 0;
            wM = condOld;
            histQ.push_back(smp);
            if (histQ.size() > D) void'(histQ.pop_front());
            if (histQ.size() == D) begin
                for (int i = 0; i < 3; i++) begin
                    allDiff = 1'b1;
                    foreach (histQ[j]) if (histQ[j][i] == dm[i]) allDiff = 1'b0;
                    if (allDiff) dm[i] = smp[i];
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rk, input logic rp, input logic rs, input logic rr);
        k   = rk;
        p   = rp;
        s   = rs;
        rst = rr;
        @(posedge clk);
        modelEdge({rk, rp, rs}, rr);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic expLamp;
        logic expChime;
        expLamp  = wM && ((ageM % (2 * BH)) < BH);
        expChime = wM && (ageM < CC);
        testsRun++;
        assert (w === wM) else begin
            testsFailed++;
            $error("[TB] FAIL %s.w observed=%b expected=%b", tag, w, wM);
        end
        testsRun++;
        assert (lamp === expLamp) else begin
            testsFailed++;
            $error("[TB] FAIL %s.lamp observed=%b expected=%b", tag, lamp, expLamp);
        end
        testsRun++;
        assert (chime === expChime) else begin
            testsFailed++;
            $error("[TB] FAIL %s.chime observed=%b expected=%b", tag, chime, expChime);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int rise;
        int fall;
        int chimeCnt;
        int warnAge;
        int wDrops;
        logic lampAt0;
        logic lampAt8;
        logic lampAt16;
        logic [2:0] pat;
        logic rr;
        int hold;

        k = 1'b0; p = 1'b0; s = 1'b0; rst = 1'b1;
        lampAt0 = 1'bx; lampAt8 = 1'bx; lampAt16 = 1'bx;

        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("reset");
        checkVal("reset_w", {31'd0, w}, 32'd0);
        checkVal("reset_lamp", {31'd0, lamp}, 32'd0);
        checkVal("reset_chime", {31'd0, chime}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("v000");
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("v010");
        end

        // First warning episode: latency, chime length and blink phase.
        rise = 0; chimeCnt = 0; warnAge = 0;
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("v110");
            if (w === 1'b1) begin
                if (rise == 0) rise = i;
                if (warnAge == 0)  lampAt0  = lamp;
                if (warnAge == 8)  lampAt8  = lamp;
                if (warnAge == 16) lampAt16 = lamp;
                warnAge++;
            end
            if (chime === 1'b1) chimeCnt++;
        end
        checkVal("riseLatency", rise, 5);
        checkVal("chimeLength", chimeCnt, CC);
        checkVal("lampFirst", {31'd0, lampAt0}, 32'd1);
        checkVal("lampAge8", {31'd0, lampAt8}, 32'd0);
        checkVal("lampAge16", {31'd0, lampAt16}, 32'd1);

        // Short belt glitch must not clear the warning.
        wDrops = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1, 1, (i < 3) ? 1'b1 : 1'b0, 0);
            checkOutput("glitch");
            if (w !== 1'b1) wDrops++;
        end
        checkVal("glitchDrops", wDrops, 0);

        fall = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 1, 1, 0);
            checkOutput("v111");
            if (w === 1'b0 && fall == 0) fall = i;
        end
        checkVal("fallLatency", fall, 5);

        // Second episode restarts the chime.
        rise = 0; chimeCnt = 0;
        for (int i = 1; i <= 50; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("restart");
            if (w === 1'b1 && rise == 0) rise = i;
            if (chime === 1'b1) chimeCnt++;
        end
        checkVal("restartRise", rise, 5);
        checkVal("restartChime", chimeCnt, CC);

        applyStimulus(1, 1, 0, 1);
        checkOutput("midReset");
        checkVal("midReset_w", {31'd0, w}, 32'd0);
        rise = 0; chimeCnt = 0;
        for (int i = 1; i <= 45; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("postReset");
            if (w === 1'b1 && rise == 0) begin
                rise = i;
                checkVal("postResetChimeOn", {31'd0, chime}, 32'd1);
            end
            if (chime === 1'b1) chimeCnt++;
        end
        checkVal("postResetRise", rise, 5);
        checkVal("postResetChime", chimeCnt, CC);

        // Random switch activity biased toward warning conditions.
        for (int n = 0; n < 150; n++) begin
            pat[2] = ($urandom_range(0, 3) != 0);
            pat[1] = ($urandom_range(0, 3) != 0);
            pat[0] = ($urandom_range(0, 2) == 0);
            rr     = ($urandom_range(0, 49) == 0);
            hold   = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                applyStimulus(pat[2], pat[1], pat[0], (h == 0) ? rr : 1'b0);
                checkOutput("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
